// File: rtl/spi_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : spi_pkg
//  Brief    : Shared types and constants for the SPI shift engine slice.
//  Revision : 1.0 - initial release
// ============================================================================
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        SHIFT = 3'd2,
        STORE = 3'd3,
        DONE  = 3'd4
    } spi_state_e;

    // Register offsets of the AXI-Lite SPI block above this engine
    localparam logic [7:0] c_REG_CTRL   = 8'h00;
    localparam logic [7:0] c_REG_STATUS = 8'h04;
    localparam logic [7:0] c_REG_START  = 8'h08;
    localparam logic [7:0] c_REG_RESET  = 8'h0C;
    localparam logic [7:0] c_REG_ISR    = 8'h10;
    localparam logic [7:0] c_REG_TXDATA = 8'h14;
    localparam logic [7:0] c_REG_RXDATA = 8'h18;

    localparam int c_CTRL_CPOL = 0;
    localparam int c_CTRL_CPHA = 1;
    localparam int c_ISR_DONE  = 1;

endpackage
`default_nettype wire

// File: rtl/spi_clk_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : spi_clk_gen
//  Brief    : Half-period divider emitting leading/trailing SCLK edge strobes.
//  Revision : 1.0 - initial release
// ============================================================================
module spi_clk_gen #(
    parameter int DIV_W  = 16,
    parameter int DATA_W = 8
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic                          en,
    input  logic [DIV_W-1:0]              div,
    output logic                          lead_edge,
    output logic                          trail_edge,
    output logic [$clog2(2*DATA_W)-1:0]   edge_cnt
);

    logic [DIV_W-1:0]            r_cnt;
    logic [$clog2(2*DATA_W)-1:0] r_edge_cnt;
    logic                        w_tick;

    assign w_tick     = en && (r_cnt == '0);
    assign lead_edge  = w_tick && !r_edge_cnt[0];
    assign trail_edge = w_tick &&  r_edge_cnt[0];
    assign edge_cnt   = r_edge_cnt;

    // Held at the reload value while disabled so every SHIFT starts a full half-period
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_cnt      <= '0;
            r_edge_cnt <= '0;
        end else if (!en) begin
            r_cnt      <= div - 1'b1;
            r_edge_cnt <= '0;
        end else if (w_tick) begin
            r_cnt      <= div - 1'b1;
            r_edge_cnt <= r_edge_cnt + 1'b1;
        end else begin
            r_cnt      <= r_cnt - 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/spi_shift_engine.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : spi_shift_engine
//  Brief    : Drains the TX FIFO over SPI, pushing received bytes to the RX FIFO.
//  Revision : 1.0 - initial release
// ============================================================================
module spi_shift_engine
    import spi_pkg::*;
#(
    parameter int DIV_W  = 16,
    parameter int DATA_W = 8
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              soft_rst,
    input  logic              start,
    input  logic              cpol,
    input  logic              cpha,
    input  logic [DIV_W-1:0]  clk_div,
    input  logic              tx_empty,
    input  logic [DATA_W-1:0] tx_data,
    output logic              tx_rd,
    input  logic              rx_full,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_wr,
    output logic              busy,
    output logic              done,
    output logic              rx_ovf,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso,
    output logic              sample_dbg
);

    localparam int                c_EW        = $clog2(2*DATA_W);
    localparam logic [c_EW-1:0]   c_LAST_EDGE = c_EW'(2*DATA_W-1);

    spi_state_e        r_state;
    spi_state_e        w_state_nxt;
    logic              r_cpol;
    logic              r_cpha;
    logic [DIV_W-1:0]  r_div;
    logic [DATA_W-1:0] r_tx_sh;
    logic [DATA_W-1:0] r_rx_sh;
    logic [DATA_W-1:0] r_rx_data;
    logic              r_sclk;
    logic              r_mosi;

    logic              w_lead;
    logic              w_trail;
    logic [c_EW-1:0]   w_edge_cnt;
    logic              w_sample;
    logic              w_shift_out;
    logic              w_last_edge;
    logic [DATA_W-1:0] w_rx_next;
    logic [DIV_W-1:0]  w_div_clamped;
    logic              w_tx_rd;
    logic              w_rx_wr;
    logic              w_rx_ovf;
    logic              w_done;

    spi_clk_gen #(
        .DIV_W  (DIV_W),
        .DATA_W (DATA_W)
    ) u_clk_gen (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .en         (r_state == SHIFT),
        .div        (r_div),
        .lead_edge  (w_lead),
        .trail_edge (w_trail),
        .edge_cnt   (w_edge_cnt)
    );

    assign w_div_clamped = (clk_div == '0) ? DIV_W'(1) : clk_div;
    assign w_sample      = r_cpha ? w_trail : w_lead;
    assign w_shift_out   = r_cpha ? w_lead  : w_trail;
    assign w_last_edge   = w_trail && (w_edge_cnt == c_LAST_EDGE);
    assign w_rx_next     = w_sample ? {r_rx_sh[DATA_W-2:0], miso} : r_rx_sh;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_tx_rd     = 1'b0;
        w_rx_wr     = 1'b0;
        w_rx_ovf    = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = tx_empty ? DONE : LOAD;
                end
            end
            LOAD: begin
                w_tx_rd     = 1'b1;
                w_state_nxt = SHIFT;
            end
            SHIFT: begin
                if (w_last_edge) begin
                    w_state_nxt = STORE;
                end
            end
            STORE: begin
                w_rx_wr     = !rx_full;
                w_rx_ovf    = rx_full;
                w_state_nxt = tx_empty ? DONE : LOAD;
            end
            DONE: begin
                w_done      = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
        // Abort wins over everything, including a start in the same cycle
        if (soft_rst) begin
            w_state_nxt = IDLE;
            w_tx_rd     = 1'b0;
            w_rx_wr     = 1'b0;
            w_rx_ovf    = 1'b0;
            w_done      = 1'b0;
        end
    end

    // TX shifter is pre-aligned so the next outgoing bit always sits at the MSB
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_cpol    <= 1'b0;
            r_cpha    <= 1'b0;
            r_div     <= DIV_W'(1);
            r_tx_sh   <= '0;
            r_rx_sh   <= '0;
            r_rx_data <= '0;
            r_sclk    <= 1'b0;
            r_mosi    <= 1'b0;
        end else if (soft_rst) begin
            r_sclk    <= r_cpol;
            r_mosi    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_cpol <= cpol;
                        r_cpha <= cpha;
                        r_div  <= w_div_clamped;
                        r_sclk <= cpol;
                    end
                end
                LOAD: begin
                    r_rx_sh <= '0;
                    if (r_cpha) begin
                        r_tx_sh <= tx_data;
                    end else begin
                        r_tx_sh <= {tx_data[DATA_W-2:0], 1'b0};
                        r_mosi  <= tx_data[DATA_W-1];
                    end
                end
                SHIFT: begin
                    if (w_lead || w_trail) begin
                        r_sclk <= ~r_sclk;
                    end
                    if (w_shift_out) begin
                        r_mosi  <= r_tx_sh[DATA_W-1];
                        r_tx_sh <= {r_tx_sh[DATA_W-2:0], 1'b0};
                    end
                    r_rx_sh <= w_rx_next;
                    if (w_last_edge) begin
                        r_rx_data <= w_rx_next;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign tx_rd      = w_tx_rd;
    assign rx_wr      = w_rx_wr;
    assign rx_ovf     = w_rx_ovf;
    assign done       = w_done;
    assign busy       = (r_state != IDLE);
    assign rx_data    = r_rx_data;
    assign sclk       = r_sclk;
    assign mosi       = r_mosi;
    assign sample_dbg = w_sample;

endmodule
`default_nettype wire
